acumulador_com_sinal: RTL and testbench
=======================================

# acumulador_com_sinal

Downstream stage of the signed/unsigned adder. It consumes the adder's 8-bit result together with the 2-bit operation code that produced it. Each sample is extended according to that code and accumulated over a frame of `N_AMOSTRAS` samples. The frame total and a sticky overflow flag are presented on a valid/ready output port.

## Interface

Parameters:
- `N_AMOSTRAS`, default 4: samples per frame; must be ≥ 1.
- `LARGURA_ACC`, default 12: accumulator and result width in bits; must be ≥ 9.

Ports:
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `entrada_valida`  in  1  upstream has a sample on `entrada` / `codigo`.
- `entrada`  in  8  adder result (the adder's `saida`).
- `codigo`  in  2  operation code that produced `entrada`.
- `entrada_pronta`  out  1  block accepts a sample this cycle.
- `saida_valida`  out  1  `soma` / `estouro` hold a completed frame.
- `saida_pronta`  in  1  downstream takes the frame.
- `soma`  out  LARGURA_ACC  frame total, two's complement.
- `estouro`  out  1  signed overflow occurred at some point in this frame.

## Operation

- Sample acceptance: a sample is accepted on a rising edge when `entrada_valida` = 1 and `entrada_pronta` = 1.
- Extension rule for each accepted sample:
  - `codigo` = 1: zero-extend `entrada` to `LARGURA_ACC` bits.
  - `codigo` = 0, 2 or 3: sign-extend `entrada`.
  - The code is evaluated per sample, so codes may be mixed within one frame.
- Accumulation:
  - Compute `acc + ext(entrada)` at `LARGURA_ACC`+1 bits, with both operands sign-extended.
  - The accumulator keeps the low `LARGURA_ACC` bits, so it wraps and never saturates.
  - Overflow is detected when the top two bits of the wide sum differ. `estouro` then sets and stays set until the frame is handed off.
- State machine with two states:
  - ACUMULA:
    - `entrada_pronta` = 1.
    - Each accepted sample updates `acc` and increments `cont`.
    - Accepting the sample where `cont` = `N_AMOSTRAS`-1 loads `soma` with the final total and `estouro` with the final flag, then moves to ENTREGA.
  - ENTREGA:
    - `entrada_pronta` = 0 and `saida_valida` = 1.
    - `entrada_valida` is ignored.
    - When `saida_pronta` = 1: clear `acc`, `cont` and the internal overflow flag, then return to ACUMULA.
- Output stability: while `saida_valida` = 1, `soma` and `estouro` are held stable.
- `entrada_pronta` is a combinational decode of the state. It never depends on `saida_pronta`, so there is no pass-through path from output ready to input ready.

## Timing

- Reset:
  - A rising edge with `rst_n` = 0 forces state ACUMULA and clears `acc`, `cont`, `soma` and `estouro` to 0. `saida_valida` is 0.
  - No sample is accepted on an edge where `rst_n` = 0.
  - `entrada_pronta` = 1 from the first cycle after reset.
- Reset mid-frame discards the partial frame. Reset during ENTREGA discards the pending result.
- Throughput in ACUMULA: one sample per cycle.
- Output latency: `saida_valida` rises on the edge that accepts the last sample of a frame.
- Frame hand-off:
  - The hand-off edge (`saida_valida` = 1 and `saida_pronta` = 1) lowers `saida_valida` and raises `entrada_pronta` in the same cycle.
  - A new sample is therefore accepted at the earliest on the edge after the hand-off.
  - Minimum period per frame: `N_AMOSTRAS`+1 cycles.
- `N_AMOSTRAS` = 1: every accepted sample goes straight to ENTREGA.
- `cont` width is ceil(log2(`N_AMOSTRAS`)), minimum 1 bit; it wraps only through the transition to ENTREGA.

## Test plan

- Signed frame (default parameters):
  - Stimulus: 4 back-to-back samples of 0xFF with `codigo` = 0, then `saida_pronta` = 1.
  - Response: `soma` = 0xFFC (−4), `estouro` = 0; `saida_valida` high for exactly 1 cycle.
- Unsigned frame:
  - Stimulus: 4 samples of 0xFF with `codigo` = 1.
  - Response: `soma` = 0x3FC (1020), `estouro` = 0.
- Mixed codes in one frame:
  - Stimulus: 0x80 with `codigo` = 0, 0x80 with `codigo` = 1, 0x01 with `codigo` = 3, 0x01 with `codigo` = 2.
  - Response: `soma` = 0x002.
- Overflow and wrap:
  - Stimulus: `LARGURA_ACC` = 9, 4 samples of 0x7F with `codigo` = 0.
  - Response: `soma` = 0x1FC (508 wrapped to −4), `estouro` = 1.
  - The next clean frame reports `estouro` = 0.
- Backpressure:
  - Stimulus: hold `saida_pronta` = 0 for 3 cycles after the frame completes, and drive `entrada_valida` = 1 with new data throughout.
  - Response: `soma` and `estouro` stable; `entrada_pronta` = 0; no sample accepted.
  - The first new sample is accepted on the edge after the hand-off.
- Reset mid-frame:
  - Stimulus: accept 2 samples of 0x10, drive `rst_n` = 0 for 1 cycle, then send 4 samples of 0x01 with `codigo` = 1.
  - Response: `soma` = 0x004, `estouro` = 0.

Source files
------------

// File: rtl/acumulador_com_sinal_if.sv
// Handshake bundle between the adder, the frame accumulator and its consumer.
// The input side carries adder samples; the output side carries frame totals.
interface acumulador_com_sinal_if #(
  parameter int LARGURA_ACC = 12
);

  logic                   entrada_valida;
  logic [7:0]             entrada;
  logic [1:0]             codigo;
  logic                   entrada_pronta;
  logic                   saida_valida;
  logic                   saida_pronta;
  logic [LARGURA_ACC-1:0] soma;
  logic                   estouro;

  // Producer/consumer side: drives samples and output-ready, observes the results
  modport master (
    output entrada_valida, entrada, codigo, saida_pronta,
    input  entrada_pronta, saida_valida, soma, estouro
  );

  // Accumulator side
  modport slave (
    input  entrada_valida, entrada, codigo, saida_pronta,
    output entrada_pronta, saida_valida, soma, estouro
  );

endinterface

// File: rtl/acumulador_com_sinal.sv
// Frame accumulator placed after the signed/unsigned adder.
// Each sample is extended according to its operation code (code 1 = unsigned)
// and added into a wrapping accumulator. After N_AMOSTRAS samples the total and
// a sticky signed-overflow flag are held on the output until they are taken.
module acumulador_com_sinal #(
  parameter int N_AMOSTRAS  = 4,
  parameter int LARGURA_ACC = 12
) (
  input logic                 clk,
  input logic                 rst_n,
  acumulador_com_sinal_if.slave bus
);

  localparam int LARGURA_CONT = (N_AMOSTRAS > 1) ? $clog2(N_AMOSTRAS) : 1;
  localparam logic [LARGURA_CONT-1:0] ULTIMA = LARGURA_CONT'(N_AMOSTRAS - 1);

  typedef enum logic [0:0] {
    ACUMULA = 1'b0,
    ENTREGA = 1'b1
  } estado_t;

  estado_t                 estado;
  logic [LARGURA_ACC-1:0]  acc;
  logic [LARGURA_CONT-1:0] cont;
  logic                    estouro_acc;
  logic [LARGURA_ACC-1:0]  soma_reg;
  logic                    estouro_reg;

  logic [LARGURA_ACC-1:0]  ext;
  logic [LARGURA_ACC:0]    soma_larga;
  logic [LARGURA_ACC-1:0]  acc_prox;
  logic                    estouro_prox;
  logic                    aceita;

  // Extend the sample (zero-extend only for code 1) and form the one-bit-wider
  // sum; differing top bits of that sum mean the signed result did not fit
  always_comb begin
    ext          = '0;
    soma_larga   = '0;
    acc_prox     = '0;
    estouro_prox = 1'b0;
    if (bus.codigo == 2'd1) begin
      ext = {{(LARGURA_ACC-8){1'b0}}, bus.entrada};
    end else begin
      ext = {{(LARGURA_ACC-8){bus.entrada[7]}}, bus.entrada};
    end
    soma_larga   = {acc[LARGURA_ACC-1], acc} + {ext[LARGURA_ACC-1], ext};
    acc_prox     = soma_larga[LARGURA_ACC-1:0];
    estouro_prox = estouro_acc | (soma_larga[LARGURA_ACC] ^ soma_larga[LARGURA_ACC-1]);
  end

  assign aceita             = (estado == ACUMULA) && bus.entrada_valida;
  assign bus.entrada_pronta = (estado == ACUMULA);
  assign bus.saida_valida   = (estado == ENTREGA);
  assign bus.soma           = soma_reg;
  assign bus.estouro        = estouro_reg;

  // Frame state machine: accumulate samples, capture the final total on the
  // last one, then hold it until downstream takes it and start a fresh frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado      <= ACUMULA;
      acc         <= '0;
      cont        <= '0;
      estouro_acc <= 1'b0;
      soma_reg    <= '0;
      estouro_reg <= 1'b0;
    end else begin
      case (estado)
        ACUMULA: begin
          if (aceita) begin
            acc         <= acc_prox;
            cont        <= cont + 1'b1;
            estouro_acc <= estouro_prox;
            if (cont == ULTIMA) begin
              soma_reg    <= acc_prox;
              estouro_reg <= estouro_prox;
              estado      <= ENTREGA;
            end
          end
        end
        ENTREGA: begin
          if (bus.saida_pronta) begin
            acc         <= '0;
            cont        <= '0;
            estouro_acc <= 1'b0;
            estado      <= ACUMULA;
          end
        end
        default: estado <= ACUMULA;
      endcase
    end
  end

endmodule

// File: tb/tb_acumulador_com_sinal.sv
// Directed bench for acumulador_com_sinal. Two instances share the same stimulus:
// the default 12-bit accumulator and a 9-bit one used for the overflow/wrap case.
module tb_acumulador_com_sinal;

  logic       clk;
  logic       rst_n;
  logic       entrada_valida;
  logic [7:0] entrada;
  logic [1:0] codigo;
  logic       saida_pronta;

  int check_count;
  int pass_count;

  acumulador_com_sinal_if #(.LARGURA_ACC(12)) bus12 ();
  acumulador_com_sinal_if #(.LARGURA_ACC(9))  bus9 ();

  assign bus12.entrada_valida = entrada_valida;
  assign bus12.entrada        = entrada;
  assign bus12.codigo         = codigo;
  assign bus12.saida_pronta   = saida_pronta;
  assign bus9.entrada_valida  = entrada_valida;
  assign bus9.entrada         = entrada;
  assign bus9.codigo          = codigo;
  assign bus9.saida_pronta    = saida_pronta;

  acumulador_com_sinal #(.N_AMOSTRAS(4), .LARGURA_ACC(12)) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus12.slave)
  );

  acumulador_com_sinal #(.N_AMOSTRAS(4), .LARGURA_ACC(9)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus9.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one sample across a rising edge, then settle 1 ns past the edge
  task automatic applyStimulus(input logic valid, input logic [7:0] dado,
                               input logic [1:0] cod);
    entrada_valida = valid;
    entrada        = dado;
    codigo         = cod;
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with no sample offered
  task automatic idleCycle();
    entrada_valida = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Hand the pending frame off and confirm the one-cycle valid pulse ended
  task automatic handOff(input string tag);
    saida_pronta = 1'b1;
    @(posedge clk);
    #1;
    saida_pronta = 1'b0;
    checkOutput({tag, "_valid_low"}, 32'(bus12.saida_valida), 32'd0);
    checkOutput({tag, "_ready_high"}, 32'(bus12.entrada_pronta), 32'd1);
  endtask

  initial begin
    check_count    = 0;
    pass_count     = 0;
    rst_n          = 1'b0;
    entrada_valida = 1'b0;
    entrada        = 8'h00;
    codigo         = 2'd0;
    saida_pronta   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_valid",   32'(bus12.saida_valida),   32'd0);
    checkOutput("rst_ready",   32'(bus12.entrada_pronta), 32'd1);
    checkOutput("rst_soma",    32'(bus12.soma),           32'h000);
    checkOutput("rst_estouro", 32'(bus12.estouro),        32'd0);

    // Signed frame: 4 x -1 = -4
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hFF, 2'd0);
      if (i == 2) checkOutput("sig_not_yet_valid", 32'(bus12.saida_valida), 32'd0);
    end
    entrada_valida = 1'b0;
    checkOutput("sig_valid",   32'(bus12.saida_valida), 32'd1);
    checkOutput("sig_ready",   32'(bus12.entrada_pronta), 32'd0);
    checkOutput("sig_soma",    32'(bus12.soma),    32'hFFC);
    checkOutput("sig_estouro", 32'(bus12.estouro), 32'd0);
    checkOutput("sig_soma9",   32'(bus9.soma),     32'h1FC);
    handOff("sig");

    // Unsigned frame: 4 x 255 = 1020
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hFF, 2'd1);
    entrada_valida = 1'b0;
    checkOutput("uns_soma",    32'(bus12.soma),    32'h3FC);
    checkOutput("uns_estouro", 32'(bus12.estouro), 32'd0);
    handOff("uns");

    // Mixed codes: -128 + 128 + 1 + 1 = 2
    applyStimulus(1'b1, 8'h80, 2'd0);
    applyStimulus(1'b1, 8'h80, 2'd1);
    applyStimulus(1'b1, 8'h01, 2'd3);
    applyStimulus(1'b1, 8'h01, 2'd2);
    entrada_valida = 1'b0;
    checkOutput("mix_soma",    32'(bus12.soma),    32'h002);
    checkOutput("mix_estouro", 32'(bus12.estouro), 32'd0);
    handOff("mix");

    // Overflow and wrap: 4 x 127 = 508, wraps to -4 at 9 bits
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h7F, 2'd0);
    entrada_valida = 1'b0;
    checkOutput("ovf_soma9",    32'(bus9.soma),     32'h1FC);
    checkOutput("ovf_estouro9", 32'(bus9.estouro),  32'd1);
    checkOutput("ovf_soma12",   32'(bus12.soma),    32'h1FC);
    checkOutput("ovf_estouro12", 32'(bus12.estouro), 32'd0);
    handOff("ovf");

    // Clean frame after overflow: flag must be cleared
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h01, 2'd0);
    entrada_valida = 1'b0;
    checkOutput("clean_soma9",    32'(bus9.soma),    32'h004);
    checkOutput("clean_estouro9", 32'(bus9.estouro), 32'd0);
    handOff("clean");

    // Backpressure: frame of 4 x 2 = 8, then new data offered while held
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h02, 2'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h55, 2'd1);
      checkOutput("bp_valid",   32'(bus12.saida_valida),   32'd1);
      checkOutput("bp_ready",   32'(bus12.entrada_pronta), 32'd0);
      checkOutput("bp_soma",    32'(bus12.soma),           32'h008);
      checkOutput("bp_estouro", 32'(bus12.estouro),        32'd0);
    end
    // Hand-off edge with a sample still offered: that sample must not count
    handOff("bp");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h55, 2'd1);
    checkOutput("bp_after_3", 32'(bus12.saida_valida), 32'd0);
    applyStimulus(1'b1, 8'h55, 2'd1);
    entrada_valida = 1'b0;
    checkOutput("bp_after_4", 32'(bus12.saida_valida), 32'd1);
    checkOutput("bp_new_soma", 32'(bus12.soma), 32'h154);
    handOff("bp2");

    // Reset mid-frame discards the partial sum
    applyStimulus(1'b1, 8'h10, 2'd0);
    applyStimulus(1'b1, 8'h10, 2'd0);
    entrada_valida = 1'b0;
    rst_n = 1'b0;
    idleCycle();
    rst_n = 1'b1;
    checkOutput("mrst_valid", 32'(bus12.saida_valida),   32'd0);
    checkOutput("mrst_ready", 32'(bus12.entrada_pronta), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h01, 2'd1);
    entrada_valida = 1'b0;
    checkOutput("mrst_valid_end", 32'(bus12.saida_valida), 32'd1);
    checkOutput("mrst_soma",      32'(bus12.soma),         32'h004);
    checkOutput("mrst_estouro",   32'(bus12.estouro),      32'd0);

    // Reset while a result is pending discards it
    rst_n = 1'b0;
    idleCycle();
    rst_n = 1'b1;
    checkOutput("erst_valid",   32'(bus12.saida_valida), 32'd0);
    checkOutput("erst_soma",    32'(bus12.soma),         32'h000);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
